// File: rtl/rr_grant_reg.sv
// Registered round-robin arbiter: one-hot grant held under a valid/ready handshake,
// with a priority pointer that rotates past each accepted winner.
module rr_grant_reg #(
  parameter int unsigned N = 2
) (
  input  logic         CLK,
  input  logic         ASYNCRESETN,
  input  logic [N-1:0] REQ,
  output logic [N-1:0] GNT,
  output logic         GNT_VALID,
  input  logic         GNT_READY
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {StIdle, StGrant} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win_q, win_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          gnt_valid_q, gnt_valid_d;

  logic [PW-1:0] base;
  logic [PW-1:0] idx;
  logic [PW-1:0] win_sel;
  logic          found;

  // While granting, the next winner is searched from the slot after the current one,
  // which is exactly where the pointer lands if this edge completes the handshake.
  always_comb begin
    base    = (state_q == StGrant) ? PW'(win_q + 1'b1) : ptr_q;
    win_sel = base;
    found   = 1'b0;
    idx     = base;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PW'(base + PW'(i));
      if (!found && REQ[idx]) begin
        win_sel = idx;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          win_d       = win_sel;
          gnt_d       = {{(N-1){1'b0}}, 1'b1} << win_sel;
          gnt_valid_d = 1'b1;
          state_d     = StGrant;
        end
      end
      StGrant: begin
        if (GNT_READY) begin
          ptr_d = PW'(win_q + 1'b1);
          if (found) begin
            win_d = win_sel;
            gnt_d = {{(N-1){1'b0}}, 1'b1} << win_sel;
          end else begin
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            state_d     = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      win_q       <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign GNT       = gnt_q;
  assign GNT_VALID = gnt_valid_q;

endmodule

// File: tb/tb_rr_grant_reg.sv
// Directed bench for rr_grant_reg: a 2-requester and a 4-requester instance share
// clock and reset; expected grants are worked out by hand for each step.
module tb_rr_grant_reg;

  logic       clk;
  logic       rst_n;
  logic [1:0] req2;
  logic       ready2;
  logic [1:0] gnt2;
  logic       valid2;
  logic [3:0] req4;
  logic       ready4;
  logic [3:0] gnt4;
  logic       valid4;

  int checks = 0;
  int errors = 0;

  rr_grant_reg #(.N(2)) u_dut2 (
    .CLK         (clk),
    .ASYNCRESETN (rst_n),
    .REQ         (req2),
    .GNT         (gnt2),
    .GNT_VALID   (valid2),
    .GNT_READY   (ready2)
  );

  rr_grant_reg #(.N(4)) u_dut4 (
    .CLK         (clk),
    .ASYNCRESETN (rst_n),
    .REQ         (req4),
    .GNT         (gnt4),
    .GNT_VALID   (valid4),
    .GNT_READY   (ready4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    req2   = 2'b11;
    ready2 = 1'b0;
    req4   = 4'b0000;
    ready4 = 1'b0;

    // Reset held with requests pending and clocks running.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_gnt", 32'(gnt2), 32'h0);
      chk("rst_valid", 32'(valid2), 32'h0);
    end
    chk("rst_gnt4", 32'(gnt4), 32'h0);

    // Release with REQ=11, READY=1: alternate 01,10,01,10.
    rst_n  = 1'b1;
    ready2 = 1'b1;
    tick(); chk("fair_c1", 32'(gnt2), 32'h1); chk("fair_v1", 32'(valid2), 32'h1);
    tick(); chk("fair_c2", 32'(gnt2), 32'h2); chk("fair_v2", 32'(valid2), 32'h1);
    tick(); chk("fair_c3", 32'(gnt2), 32'h1); chk("fair_v3", 32'(valid2), 32'h1);
    tick(); chk("fair_c4", 32'(gnt2), 32'h2); chk("fair_v4", 32'(valid2), 32'h1);

    // Accept 10 with no requests: back to idle, pointer wraps to 0.
    req2 = 2'b00;
    tick(); chk("drain_gnt", 32'(gnt2), 32'h0); chk("drain_valid", 32'(valid2), 32'h0);
    chk("drain_ptr", 32'(u_dut2.ptr_q), 32'h0);

    // Hold and revoke-immunity.
    req2 = 2'b10; ready2 = 1'b0;
    tick(); chk("hold_load", 32'(gnt2), 32'h2);
    req2 = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_gnt", 32'(gnt2), 32'h2);
      chk("hold_valid", 32'(valid2), 32'h1);
    end
    ready2 = 1'b1;
    tick(); chk("accept_gnt", 32'(gnt2), 32'h0); chk("accept_valid", 32'(valid2), 32'h0);
    chk("accept_ptr", 32'(u_dut2.ptr_q), 32'h0);

    // Single requester back-to-back: index 0 wins every cycle via wrap.
    req2 = 2'b01;
    tick(); chk("single_c1", 32'(gnt2), 32'h1); chk("single_v1", 32'(valid2), 32'h1);
    tick(); chk("single_c2", 32'(gnt2), 32'h1); chk("single_v2", 32'(valid2), 32'h1);
    chk("single_ptr2", 32'(u_dut2.ptr_q), 32'h1);
    tick(); chk("single_c3", 32'(gnt2), 32'h1); chk("single_v3", 32'(valid2), 32'h1);
    chk("single_ptr3", 32'(u_dut2.ptr_q), 32'h1);

    // Accept with no requests (ptr=1), then grant 10 and reset mid-grant.
    req2 = 2'b00;
    tick(); chk("pre_rst_idle", 32'(valid2), 32'h0);
    req2 = 2'b10; ready2 = 1'b0;
    tick(); chk("pre_rst_gnt", 32'(gnt2), 32'h2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_gnt", 32'(gnt2), 32'h0);
    chk("async_valid", 32'(valid2), 32'h0);
    req2 = 2'b11;
    tick();
    rst_n = 1'b1;
    tick(); chk("post_rst_gnt", 32'(gnt2), 32'h1); chk("post_rst_valid", 32'(valid2), 32'h1);
    ready2 = 1'b0;

    // N=4 wrap: grant 1000, accept with REQ=1001 -> 0001, then 1000.
    req4 = 4'b1000; ready4 = 1'b0;
    tick(); chk("w4_1000", 32'(gnt4), 32'h8); chk("w4_v", 32'(valid4), 32'h1);
    req4 = 4'b1001; ready4 = 1'b1;
    tick(); chk("w4_0001", 32'(gnt4), 32'h1);
    chk("w4_ptr0", 32'(u_dut4.ptr_q), 32'h0);
    tick(); chk("w4_1000b", 32'(gnt4), 32'h8);
    // Move pointer to 3 by accepting index 2, then idle.
    req4 = 4'b0100;
    tick(); chk("w4_0100", 32'(gnt4), 32'h4);
    req4 = 4'b0000;
    tick(); chk("w4_idle", 32'(valid4), 32'h0);
    chk("w4_ptr3", 32'(u_dut4.ptr_q), 32'h3);
    req4 = 4'b0110; ready4 = 1'b0;
    tick(); chk("w4_0010", 32'(gnt4), 32'h2); chk("w4_v2", 32'(valid4), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
